axi_isolate_ctrl: RTL and testbench



---
 rtl/axi_isolate_ctrl_pkg.sv | 20 ++
 rtl/axi_isolate_req_filter.sv | 43 ++++
 rtl/axi_isolate_ctrl.sv | 130 +++++++++++++
 tb/tb_axi_isolate_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_isolate_ctrl_pkg.sv
// Shared types and defaults for the outbound AXI isolation controller.
// The optional isolation timeout is enabled with AXI_ISOLATE_CTRL_TIMEOUT_EN.
package axi_isolate_ctrl_pkg;

  // Controller state; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_CONNECTED = 2'd0,
    ST_ISOLATING = 2'd1,
    ST_ISOLATED  = 2'd2,
    ST_RELEASING = 2'd3
  } iso_state_e;

  localparam int unsigned DefaultStableCycles  = 4;
  localparam int unsigned DefaultTimeoutCycles = 1024;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_isolate_req_filter.sv
// Stability filter for the synchronised isolate request.
// A new request level is accepted only after it has been seen on StableCycles
// consecutive clock edges. req_o already reflects an update that lands on the
// coming edge, so a consumer registering req_o reacts on that same edge and the
// end-to-end latency from an input change is exactly StableCycles cycles.
module axi_isolate_req_filter
  import axi_isolate_ctrl_pkg::*;
#(
  parameter int unsigned StableCycles = DefaultStableCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic req_o
);

  localparam int unsigned CntWidth = $clog2(StableCycles + 1);

  logic                filt_req;
  logic [CntWidth-1:0] stab_cnt;
  logic                mismatch;
  logic                settle;

  assign mismatch = (req_i != filt_req);
  assign settle   = mismatch && (stab_cnt == CntWidth'(StableCycles - 1));
  assign req_o    = settle ? req_i : filt_req;

  // Count consecutive mismatching samples; adopt the input once the run is long enough.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      filt_req <= 1'b1;
      stab_cnt <= '0;
    end else if (settle) begin
      filt_req <= req_i;
      stab_cnt <= '0;
    end else if (mismatch) begin
      stab_cnt <= stab_cnt + CntWidth'(1);
    end else begin
      stab_cnt <= '0;
    end
  end

endmodule

// File: rtl/axi_isolate_ctrl.sv
// Isolation / release sequencer for the secure subsystem's outbound AXI port.
// Handshake with the isolate stage: isolate_o is a level command; isolated_i is
// the stage's level acknowledge. A state change is reported only once
// isolated_i has followed isolate_o (high to finish isolating, low to finish
// releasing); isolated_i is ignored in CONNECTED and ISOLATED.
// Core fetch-enable is held off until the port has been connected once.
// Optional feature: define AXI_ISOLATE_CTRL_TIMEOUT_EN to raise a sticky
// timeout_o when ISOLATING lasts TimeoutCycles cycles.
module axi_isolate_ctrl
  import axi_isolate_ctrl_pkg::*;
#(
  parameter int unsigned StableCycles  = DefaultStableCycles,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       isolate_req_i,
  input  logic       fetch_en_i,
  input  logic       isolated_i,
  output logic       isolate_o,
  output logic       isolated_o,
  output logic       fetch_en_o,
  output logic [1:0] state_o,
  output logic       timeout_o
);

  iso_state_e state;
  logic       filt_req;
  logic       ever_conn;

  axi_isolate_req_filter #(
    .StableCycles(StableCycles)
  ) u_req_filter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (isolate_req_i),
    .req_o (filt_req)
  );

  assign state_o = state;

  // Sequencer: state, isolate command and isolated status all move on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= ST_ISOLATED;
      isolate_o  <= 1'b1;
      isolated_o <= 1'b1;
      ever_conn  <= 1'b0;
    end else begin
      case (state)
        ST_CONNECTED: begin
          if (filt_req) begin
            state      <= ST_ISOLATING;
            isolate_o  <= 1'b1;
            isolated_o <= 1'b0;
          end
        end
        ST_ISOLATING: begin
          // A dropped request is deliberately ignored until isolation completes.
          if (isolated_i) begin
            state      <= ST_ISOLATED;
            isolate_o  <= 1'b1;
            isolated_o <= 1'b1;
          end
        end
        ST_ISOLATED: begin
          if (!filt_req) begin
            state      <= ST_RELEASING;
            isolate_o  <= 1'b0;
            isolated_o <= 1'b0;
          end
        end
        ST_RELEASING: begin
          // A renewed request wins over a completed release.
          if (filt_req) begin
            state      <= ST_ISOLATING;
            isolate_o  <= 1'b1;
            isolated_o <= 1'b0;
          end else if (!isolated_i) begin
            state      <= ST_CONNECTED;
            isolate_o  <= 1'b0;
            isolated_o <= 1'b0;
            ever_conn  <= 1'b1;
          end
        end
        default: begin
          state      <= ST_ISOLATED;
          isolate_o  <= 1'b1;
          isolated_o <= 1'b1;
        end
      endcase
    end
  end

  // Fetch gate: once connected, fetch is never withdrawn; the isolate stage cuts traffic instead.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_en_o <= 1'b0;
    end else begin
      fetch_en_o <= fetch_en_i & ever_conn;
    end
  end

`ifdef AXI_ISOLATE_CTRL_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(max_u(StableCycles, TimeoutCycles) + 1);

  logic [CntWidth-1:0] to_cnt;
  logic                to_flag;

  assign timeout_o = to_flag;

  // Dwell counter for ISOLATING; held at zero elsewhere so every entry starts from 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state != ST_ISOLATING) begin
      to_cnt <= '0;
    end else if (to_cnt != CntWidth'(TimeoutCycles)) begin
      to_cnt <= to_cnt + CntWidth'(1);
      if (to_cnt == CntWidth'(TimeoutCycles - 1)) begin
        to_flag <= 1'b1;
      end
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Bench for axi_isolate_ctrl: directed scenarios plus randomized traffic, all
// checked against a behavioural reference model of the controller.
module tb_axi_isolate_ctrl;

  localparam int S = 4;
  localparam int T = 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       isolate_req = 1'b1;
  logic       fetch_en = 1'b0;
  logic       isolated_in = 1'b1;
  logic       isolate;
  logic       isolated;
  logic       fetch_q;
  logic [1:0] state;
  logic       timeout;

  always #5 clk = ~clk;

  axi_isolate_ctrl #(
    .StableCycles (S),
    .TimeoutCycles(T)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .isolate_req_i(isolate_req),
    .fetch_en_i   (fetch_en),
    .isolated_i   (isolated_in),
    .isolate_o    (isolate),
    .isolated_o   (isolated),
    .fetch_en_o   (fetch_q),
    .state_o      (state),
    .timeout_o    (timeout)
  );

  wire [5:0] outs = {state, isolate, isolated, fetch_q, timeout};

  // ---------------- reference model + scoreboard ----------------
  // Phase numbers follow the documented state_o values.
  bit         m_filt = 1'b1;
  bit         hist[$];
  int         m_phase = 2;
  bit         m_ever = 1'b0;
  bit         m_fetch = 1'b0;
  int         m_dwell = 0;
  bit         m_to = 1'b0;
  logic [5:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;

  // Isolate-stage stand-in: isolated_i follows isolate_o after auto_dly edges.
  bit         auto_iso = 1'b1;
  int         auto_dly = 2;
  bit         iso_hist[$] = '{1'b1, 1'b1, 1'b1, 1'b1};

  task automatic model_edge();
    bit all_diff;
    if (!rst_n) begin
      m_filt = 1'b1; hist.delete(); m_phase = 2;
      m_ever = 1'b0; m_fetch = 1'b0; m_dwell = 0; m_to = 1'b0;
    end else begin
      // Request accepted once the last S samples all disagree with the current level.
      hist.push_back(isolate_req);
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i] == m_filt) all_diff = 1'b0;
        if (all_diff) m_filt = isolate_req;
      end
      m_fetch = fetch_en & m_ever;
      if (m_phase == 1) m_dwell++; else m_dwell = 0;
`ifdef AXI_ISOLATE_CTRL_TIMEOUT_EN
      if (m_dwell >= T) m_to = 1'b1;
`endif
      case (m_phase)
        0: if (m_filt) m_phase = 1;
        1: if (isolated_in) m_phase = 2;
        2: if (!m_filt) m_phase = 3;
        default: begin
          if (m_filt) m_phase = 1;
          else if (!isolated_in) m_phase = 0;
        end
      endcase
      if (m_phase == 0) m_ever = 1'b1;
    end
    exp_q.push_back({2'(m_phase), (m_phase == 1 || m_phase == 2), (m_phase == 2), m_fetch, m_to});
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    iso_hist.push_front(isolate);
    if (iso_hist.size() > 4) void'(iso_hist.pop_back());
    if (auto_iso) isolated_in = iso_hist[auto_dly-1];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [5:0] e;
    int rel_at = -1, con_at = -1, fen_at = -1;
    rst_n = 1'b0; isolate_req = 1'b0; fetch_en = 1'b1; auto_iso = 1'b1; auto_dly = 2;
    for (int k = 0; k < 3; k++) begin
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    n_chk++;
    if (outs !== 6'b10_1_1_0_0) $display("FAIL reset_values got=%b exp=%b", outs, 6'b10_1_1_0_0);
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL bringup_model cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
      if (state === 2'd3 && rel_at < 0) rel_at = k;
      if (state === 2'd0 && con_at < 0) con_at = k;
      if (fetch_q === 1'b1 && fen_at < 0) fen_at = k;
    end
    n_chk++;
    if (rel_at != 4) $display("FAIL releasing_latency got=%0d exp=4", rel_at); else n_pass++;
    n_chk++;
    if (con_at != 6) $display("FAIL connected_latency got=%0d exp=6", con_at); else n_pass++;
    n_chk++;
    if (fen_at != 7) $display("FAIL fetch_latency got=%0d exp=7", fen_at); else n_pass++;
  endtask

  task automatic test_filter_glitch();
    logic [5:0] e;
    bit pat[] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    foreach (pat[i]) begin
      isolate_req = pat[i];
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL glitch_model cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
      if (i == 8) begin
        n_chk++;
        if (state !== 2'd0) $display("FAIL glitch_ignored got=%0d exp=0", state); else n_pass++;
      end
    end
    n_chk++;
    if ({state, isolate} !== 3'b01_1) $display("FAIL isolate_on_4th got=%b exp=011", {state, isolate});
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL glitch_tail cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    n_chk++;
    if (state !== 2'd2) $display("FAIL reached_isolated got=%0d exp=2", state); else n_pass++;
  endtask

  task automatic test_drop_in_isolating();
    logic [5:0] e;
    auto_iso = 1'b1; auto_dly = 1; isolate_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (state === 2'd0) break;
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL drop_setup cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    n_chk++;
    if (state !== 2'd0) $display("FAIL drop_reach_connected got=%0d exp=0", state); else n_pass++;
    auto_iso = 1'b0; isolated_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      isolate_req = (k < 4);
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL drop_model cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    n_chk++;
    if (state !== 2'd1) $display("FAIL drop_held_isolating got=%0d exp=1", state); else n_pass++;
    isolated_in = 1'b1;
    cycle(); e = exp_q.pop_front(); n_chk++;
    if (outs !== e) $display("FAIL drop_ack cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    n_chk++;
    if ({state, isolated} !== 3'b10_1) $display("FAIL drop_isolated_first got=%b exp=101", {state, isolated});
    else n_pass++;
    cycle(); e = exp_q.pop_front(); n_chk++;
    if (outs !== e) $display("FAIL drop_release cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    n_chk++;
    if (state !== 2'd3) $display("FAIL drop_then_releasing got=%0d exp=3", state); else n_pass++;
  endtask

  task automatic test_release_race();
    logic [5:0] e;
    isolate_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL race_model cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    n_chk++;
    if (state !== 2'd3) $display("FAIL race_still_releasing got=%0d exp=3", state); else n_pass++;
    isolated_in = 1'b0;
    cycle(); e = exp_q.pop_front(); n_chk++;
    if (outs !== e) $display("FAIL race_edge cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    n_chk++;
    if ({state, isolate} !== 3'b01_1) $display("FAIL race_isolation_wins got=%b exp=011", {state, isolate});
    else n_pass++;
  endtask

  task automatic test_fetch_hold();
    logic [5:0] e;
    bit saw1 = 1'b0, saw2 = 1'b0, dropped = 1'b0;
    auto_iso = 1'b1; auto_dly = 1; isolate_req = 1'b0; fetch_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (state === 2'd0) break;
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL fetch_setup cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    isolate_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL fetch_model cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
      if (state === 2'd1) saw1 = 1'b1;
      if (state === 2'd2) saw2 = 1'b1;
      if (fetch_q !== 1'b1) dropped = 1'b1;
    end
    n_chk++;
    if (!(saw1 && saw2) || dropped)
      $display("FAIL fetch_held got=saw_iso:%0d saw_isolated:%0d dropped:%0d exp=1,1,0", saw1, saw2, dropped);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [5:0] e;
    int to_at = -1;
`ifdef AXI_ISOLATE_CTRL_TIMEOUT_EN
    int exp_to_at = T;
    bit exp_late = 1'b1;
`else
    int exp_to_at = -1;
    bit exp_late = 1'b0;
`endif
    auto_iso = 1'b1; auto_dly = 1; isolate_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (state === 2'd0) break;
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL to_setup cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    auto_iso = 1'b0; isolated_in = 1'b0; isolate_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (state === 2'd1) break;
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL to_enter cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    n_chk++;
    if (state !== 2'd1) $display("FAIL to_reach_isolating got=%0d exp=1", state); else n_pass++;
    for (int k = 1; k <= 11; k++) begin
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL to_model cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
      if (timeout === 1'b1 && to_at < 0) to_at = k;
    end
    n_chk++;
    if (to_at != exp_to_at) $display("FAIL timeout_cycle got=%0d exp=%0d", to_at, exp_to_at); else n_pass++;
    isolated_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL to_after_ack cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
    n_chk++;
    if ({state, timeout} !== {2'd2, exp_late})
      $display("FAIL timeout_sticky got=%b exp=%b", {state, timeout}, {2'd2, exp_late});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] e;
    int hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (k % 50 == 0) begin
        auto_iso = ($urandom_range(0, 3) != 0);
        auto_dly = $urandom_range(1, 3);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      if (hold == 0) begin
        isolate_req = $urandom_range(0, 1);
        hold = $urandom_range(1, 7);
      end
      hold--;
      if ($urandom_range(0, 9) == 0) fetch_en = $urandom_range(0, 1);
      if (!auto_iso) isolated_in = $urandom_range(0, 1);
      cycle(); e = exp_q.pop_front(); n_chk++;
      if (outs !== e) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, outs, e); else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_filter_glitch();
    test_drop_in_isolating();
    test_release_race();
    test_fetch_hold();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
